// File: rtl/spi_pkg.sv
// Shared SPI link constants and the initiator's state encoding.
// Pure declarations: no logic, no latency.
// Used by both the initiator and the byte receiver on the same link.
package spi_pkg;

  // Bits per serial word, sent MSB first
  localparam int SPI_BITS = 8;

  // Receiver needs at least two clk cycles per spi_clk level
  localparam int MIN_HALF_DIV = 2;
  localparam int MAX_HALF_DIV = 255;

  // Minimum spi_ss-high time between frames, in clk cycles
  localparam int MIN_GAP_CYC = 2;
  localparam int MAX_GAP_CYC = 256;

  // Initiator FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_STALL = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_t;

  // Down-counter reload for an interval of 'cycles' clk cycles
  function automatic logic [7:0] reload_val(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Interval timer: down-counter reloaded by load, expire while it sits at zero.
// An interval loaded with N-1 lasts exactly N cycles until expire.
// No backpressure; the caller reloads on expire to chain intervals.
module spi_clk_div (
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] cnt;

  // Count down toward zero; a load restarts the interval
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= 8'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign expire = (cnt == 8'd0);

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 initiator: bytes from a valid/ready stream leave MSB first on mosi.
// spi_ss falls 2 cycles after accept; one byte per 16*HALF_DIV cycles in a burst.
// One-entry holding register; tx_ready drops while it is full, no capture then.
module spi_master_tx #(
  parameter int HALF_DIV = 4,
  parameter int GAP_CYC  = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       spi_clk,
  output logic       mosi,
  output logic       spi_ss,
  output logic       busy,
  output logic       byte_done
);

  import spi_pkg::*;

  // Reject parameter values the receiver cannot follow
  if (HALF_DIV < MIN_HALF_DIV || HALF_DIV > MAX_HALF_DIV) begin : g_bad_half_div
    $error("spi_master_tx: HALF_DIV out of range");
  end
  if (GAP_CYC < MIN_GAP_CYC || GAP_CYC > MAX_GAP_CYC) begin : g_bad_gap_cyc
    $error("spi_master_tx: GAP_CYC out of range");
  end

  localparam logic [2:0] LAST_BIT    = 3'(SPI_BITS - 1);
  localparam logic [7:0] HALF_RELOAD = reload_val(HALF_DIV);
  localparam logic [7:0] GAP_RELOAD  = reload_val(GAP_CYC);

  spi_state_t state;
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       hold_last;
  logic [7:0] shift;
  logic       cur_last;
  logic [2:0] bit_cnt;
  logic       accept;
  logic       take;
  logic       div_load;
  logic [7:0] div_val;
  logic       expire;

  assign accept = tx_valid & tx_ready;

  spi_clk_div u_div (
    .clk      (clk),
    .rstn     (rstn),
    .load     (div_load),
    .load_val (div_val),
    .expire   (expire)
  );

  // Decide when the held byte moves to the shifter and when the timer restarts
  always_comb begin
    take     = 1'b0;
    div_load = 1'b0;
    div_val  = (state == ST_TRAIL) ? GAP_RELOAD : HALF_RELOAD;
    case (state)
      ST_IDLE, ST_STALL: begin
        take     = hold_valid;
        div_load = hold_valid;
      end
      ST_HIGH: begin
        take     = hold_valid && expire && (bit_cnt == LAST_BIT) && !cur_last;
        div_load = expire;
      end
      ST_LOW, ST_TRAIL, ST_GAP: begin
        div_load = expire;
      end
      default: begin
        take     = 1'b0;
        div_load = 1'b0;
      end
    endcase
  end

  // One-entry holding register; tx_ready is the registered inverse of its fill
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'd0;
      hold_last  <= 1'b0;
      tx_ready   <= 1'b1;
    end else begin
      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
      end
      hold_valid <= accept | (hold_valid & ~take);
      tx_ready   <= ~(accept | (hold_valid & ~take));
    end
  end

  // Link sequencer: half-period phases, byte chaining, trailing low and gap
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      spi_ss    <= 1'b1;
      spi_clk   <= 1'b0;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      shift     <= 8'd0;
      cur_last  <= 1'b0;
      bit_cnt   <= 3'd0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hold_valid) begin
            spi_ss   <= 1'b0;
            busy     <= 1'b1;
            shift    <= hold_data;
            cur_last <= hold_last;
            mosi     <= hold_data[7];
            bit_cnt  <= 3'd0;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (expire) begin
            spi_clk <= 1'b1;
            state   <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (expire) begin
            spi_clk <= 1'b0;
            if (bit_cnt != LAST_BIT) begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {shift[6:0], 1'b0};
              mosi    <= shift[6];
              state   <= ST_LOW;
            end else begin
              byte_done <= 1'b1;
              if (cur_last) begin
                state <= ST_TRAIL;
              end else if (hold_valid) begin
                shift    <= hold_data;
                cur_last <= hold_last;
                mosi     <= hold_data[7];
                bit_cnt  <= 3'd0;
                state    <= ST_LOW;
              end else begin
                state <= ST_STALL;
              end
            end
          end
        end
        ST_STALL: begin
          if (hold_valid) begin
            shift    <= hold_data;
            cur_last <= hold_last;
            mosi     <= hold_data[7];
            bit_cnt  <= 3'd0;
            state    <= ST_LOW;
          end
        end
        ST_TRAIL: begin
          if (expire) begin
            spi_ss <= 1'b1;
            mosi   <= 1'b0;
            state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (expire) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: instance 0 at HALF_DIV=4/GAP_CYC=8, instance 1 at 2/2.
// Stimulus pushes expected bytes and frame shapes; a negedge monitor decodes the link.
// Frame shape = spi_ss-low cycles (-1 = don't care) and rising spi_clk edge count.
module tb_spi_master_tx;

  typedef struct {
    int win;
    int edges;
  } win_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data   [2];
  logic       tx_valid  [2];
  logic       tx_last   [2];
  logic       tx_ready  [2];
  logic       spi_clk   [2];
  logic       mosi      [2];
  logic       spi_ss    [2];
  logic       busy      [2];
  logic       byte_done [2];

  logic [7:0] exp_q [$];
  win_t       win_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // monitor state per instance
  logic       prev_clk  [2];
  logic       prev_ss   [2];
  logic       prev_busy [2];
  logic       prev_bd   [2];
  logic       prev_mosi [2];
  logic [7:0] sh        [2];
  int         bits      [2];
  int         win_c     [2];
  int         edg       [2];
  int         gap       [2];
  int         bd_w      [2];
  int         bd_cnt    [2];

  always #5 clk = ~clk;

  spi_master_tx #(.HALF_DIV(4), .GAP_CYC(8)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .tx_data   (tx_data[0]),
    .tx_valid  (tx_valid[0]),
    .tx_last   (tx_last[0]),
    .tx_ready  (tx_ready[0]),
    .spi_clk   (spi_clk[0]),
    .mosi      (mosi[0]),
    .spi_ss    (spi_ss[0]),
    .busy      (busy[0]),
    .byte_done (byte_done[0])
  );

  spi_master_tx #(.HALF_DIV(2), .GAP_CYC(2)) u_min (
    .clk       (clk),
    .rstn      (rstn),
    .tx_data   (tx_data[1]),
    .tx_valid  (tx_valid[1]),
    .tx_last   (tx_last[1]),
    .tx_ready  (tx_ready[1]),
    .spi_clk   (spi_clk[1]),
    .mosi      (mosi[1]),
    .spi_ss    (spi_ss[1]),
    .busy      (busy[1]),
    .byte_done (byte_done[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_to(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // {spi_ss, spi_clk, mosi, busy, byte_done, tx_ready}
  function automatic int outs(input int i);
    return int'({26'd0, spi_ss[i], spi_clk[i], mosi[i], busy[i], byte_done[i], tx_ready[i]});
  endfunction

  // Present a byte and return just after the edge that accepts it; tx_valid stays high
  task automatic send(input int i, input logic [7:0] d, input logic l, input bit push);
    int   n;
    logic r;
    n = 0;
    @(negedge clk);
    tx_valid[i] = 1'b1;
    tx_data[i]  = d;
    tx_last[i]  = l;
    if (push) exp_q.push_back(d);
    forever begin
      r = tx_ready[i];
      @(posedge clk);
      if (r) break;
      n++;
      if (n > 3000) begin
        fail_to("send_accept");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    tx_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy[i] || !tx_ready[i]) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_to("wait_idle");
    repeat (4) @(negedge clk);
  endtask

  // Monitor: receiver model, frame shape, gap length, byte_done pulses, mosi timing
  initial begin
    logic [7:0] e;
    win_t       w;
    for (int i = 0; i < 2; i++) begin
      prev_clk[i] = 1'b0; prev_ss[i] = 1'b1; prev_busy[i] = 1'b0;
      prev_bd[i] = 1'b0; prev_mosi[i] = 1'b0; sh[i] = 8'd0;
      bits[i] = 0; win_c[i] = 0; edg[i] = 0; gap[i] = 0; bd_w[i] = 0; bd_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rstn) begin
          bits[i] = 0; win_c[i] = 0; edg[i] = 0; gap[i] = 0; bd_w[i] = 0;
        end else begin
          if (spi_clk[i] && !prev_clk[i]) begin
            sh[i] = {sh[i][6:0], mosi[i]};
            bits[i]++;
            edg[i]++;
            if (bits[i] == 8) begin
              bits[i] = 0;
              if (exp_q.size() == 0) begin
                fail_to("rx_unexpected_byte");
              end else begin
                e = exp_q.pop_front();
                chk("rx_byte", int'(sh[i]), int'(e));
              end
            end
          end
          if (mosi[i] != prev_mosi[i]) chk("mosi_change_clk_high", int'(spi_clk[i]), 0);
          if (!spi_ss[i]) win_c[i]++;
          if (spi_ss[i] && !prev_ss[i]) begin
            if (win_q.size() == 0) begin
              fail_to("unexpected_frame");
            end else begin
              w = win_q.pop_front();
              if (w.win >= 0) chk("ss_low_window", win_c[i], w.win);
              chk("rise_edges", edg[i], w.edges);
            end
            win_c[i] = 0; edg[i] = 0; gap[i] = 0;
          end
          if (spi_ss[i] && busy[i]) gap[i]++;
          if (!busy[i] && prev_busy[i]) begin
            chk("gap_len", gap[i], (i == 0) ? 8 : 2);
            gap[i] = 0;
          end
          if (byte_done[i]) bd_w[i]++;
          if (!byte_done[i] && prev_bd[i]) begin
            chk("byte_done_width", bd_w[i], 1);
            bd_cnt[i]++;
            bd_w[i] = 0;
          end
        end
        prev_clk[i]  = spi_clk[i];
        prev_ss[i]   = spi_ss[i];
        prev_busy[i] = busy[i];
        prev_bd[i]   = byte_done[i];
        prev_mosi[i] = mosi[i];
      end
    end
  end

  // Stimulus
  initial begin
    int   n;
    int   bad;
    int   rises;
    logic pc;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = 8'd0;
      tx_last[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("reset_state_dut", outs(0), 6'b100001);
    chk("reset_state_min", outs(1), 6'b100001);
    rstn = 1'b1;

    // single byte, last
    win_q.push_back(win_t'{68, 8});
    send(0, 8'hA5, 1'b1, 1'b1);
    idle(0);
    chk("ss_before_latency", int'(spi_ss[0]), 1);
    @(negedge clk);
    chk("ss_fall_latency", int'(spi_ss[0]), 0);
    chk("busy_at_start", int'(busy[0]), 1);
    wait_idle(0);

    // back-to-back burst
    win_q.push_back(win_t'{196, 24});
    send(0, 8'h3C, 1'b0, 1'b1);
    send(0, 8'hFF, 1'b0, 1'b1);
    send(0, 8'h00, 1'b1, 1'b1);
    idle(0);
    wait_idle(0);

    // underrun: frame stalls between bytes
    win_q.push_back(win_t'{-1, 16});
    send(0, 8'h81, 1'b0, 1'b1);
    idle(0);
    n = 0;
    while (!byte_done[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) fail_to("underrun_byte_done");
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (spi_clk[0] !== 1'b0 || spi_ss[0] !== 1'b0 || mosi[0] !== 1'b1) bad++;
    end
    chk("stall_lines_stable", bad, 0);
    send(0, 8'h7E, 1'b1, 1'b1);
    idle(0);
    wait_idle(0);

    // backpressure with tx_valid held high across a 4-byte stream
    win_q.push_back(win_t'{260, 32});
    send(0, 8'h01, 1'b0, 1'b1);
    send(0, 8'h02, 1'b0, 1'b1);
    #1;
    chk("ready_low_while_full", int'(tx_ready[0]), 0);
    send(0, 8'h03, 1'b0, 1'b1);
    send(0, 8'h04, 1'b1, 1'b1);
    idle(0);
    wait_idle(0);

    // reset after the 3rd rising edge of 0xC3
    send(0, 8'hC3, 1'b1, 1'b0);
    idle(0);
    n = 0;
    rises = 0;
    pc = spi_clk[0];
    while (rises < 3 && n < 1000) begin
      @(negedge clk);
      if (spi_clk[0] && !pc) rises++;
      pc = spi_clk[0];
      n++;
    end
    if (n >= 1000) fail_to("third_rising_edge");
    rstn = 1'b0;
    @(negedge clk);
    chk("reset_midframe_outputs", outs(0), 6'b100001);
    @(negedge clk);
    rstn = 1'b1;
    win_q.push_back(win_t'{68, 8});
    send(0, 8'h5A, 1'b1, 1'b1);
    idle(0);
    wait_idle(0);

    // minimum divider burst
    win_q.push_back(win_t'{66, 16});
    send(1, 8'h12, 1'b0, 1'b1);
    send(1, 8'h34, 1'b1, 1'b1);
    idle(1);
    wait_idle(1);

    chk("byte_done_count_dut", bd_cnt[0], 11);
    chk("byte_done_count_min", bd_cnt[1], 2);
    chk("rx_queue_drained", exp_q.size(), 0);
    chk("frame_queue_drained", win_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 initiator that serialises bytes onto spi_clk/mosi/spi_ss for the FPGA-side byte receiver on the same link.
- Bytes arrive on a valid/ready stream and leave MSB first.
- spi_ss stays low across a multi-byte frame until a byte flagged last has been shifted out.
- spi_clk is derived from clk by a half-period counter, so the receiver's clk-domain edge detection always sees clean edges.

Parameters:
- HALF_DIV, 4, spi_clk half-period in clk cycles; legal values are 2..255 (receiver needs at least 2 cycles per level).
- GAP_CYC, 8, minimum clk cycles spi_ss is held high between frames; legal values are at least 2.

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset
- tx_data  input  8  byte to transmit
- tx_valid  input  1  tx_data/tx_last valid
- tx_last  input  1  byte closes the frame (spi_ss rises after it)
- tx_ready  output  1  holding register empty; a transfer occurs when tx_valid & tx_ready
- spi_clk  output  1  serial clock, idles low
- mosi  output  1  serial data, changes only while spi_clk is low
- spi_ss  output  1  slave select, active low, idles high
- busy  output  1  high from frame start to end of GAP
- byte_done  output  1  one-cycle pulse on the falling spi_clk edge after each byte's 8th bit

Behaviour:
- Interface rule: reset rstn, synchronous, active-low; clock clk.
- Reset values:
  - spi_ss=1, spi_clk=0, mosi=0, busy=0, byte_done=0, tx_ready=1.
  - Holding register empty; state IDLE; divider and bit counters 0.
- Holding register: one entry {data, last}.
  - Loaded on tx_valid & tx_ready.
  - tx_ready = ~hold_valid (registered).
  - Emptied when its byte moves into the shift register.
  - The same-cycle load/unload case is allowed, so throughput is one byte per 16*HALF_DIV cycles.
- States: IDLE, LOW, HIGH, STALL, TRAIL, GAP.
- IDLE:
  - If hold_valid: next edge spi_ss=0, shift<=hold, mosi=hold.data[7], bit_cnt=0, busy=1, state LOW.
  - Latency from accept to spi_ss fall is 2 cycles.
- LOW: spi_clk=0 for HALF_DIV cycles, then spi_clk=1, state HIGH.
- HIGH: spi_clk=1 for HALF_DIV cycles; the receiver samples mosi at the rising edge. At expiry, spi_clk=0 and:
  - bit_cnt<7: bit_cnt+1, mosi=next bit (MSB first), state LOW.
  - bit_cnt==7: byte_done=1 for one cycle, then:
    - Current byte last=1: state TRAIL.
    - Else hold_valid: load next byte, mosi=its bit7, bit_cnt=0, state LOW.
    - Else: state STALL.
- STALL:
  - spi_ss=0, spi_clk=0, mosi holds its value.
  - On hold_valid: load, mosi=bit7, state LOW.
  - No timeout.
- TRAIL: spi_clk=0 for HALF_DIV cycles, then spi_ss=1, mosi=0, state GAP.
- GAP:
  - spi_ss=1 for GAP_CYC cycles, then busy=0, state IDLE.
  - tx_ready still follows the holding register, so the next byte may be accepted during GAP.
- Frame timing: a single-byte frame holds spi_ss low for exactly 17*HALF_DIV cycles, with 8 spi_clk rising edges.
- Byte-to-byte spacing: the first rising edge of a following byte comes 2*HALF_DIV after the last rising edge of the previous byte, which covers the receiver's one-cycle byte-commit slot.
- tx_last on a byte loaded during STALL is honoured.
- tx_last=0 with no further data leaves the link in STALL indefinitely. This is legal; spi_ss stays low.
- tx_valid changes while tx_ready=0 are ignored (no capture).
- Reset mid-frame: the next edge returns every output to its reset value. The held byte is discarded. No trailing edge is generated.
- Counters: div_cnt 8 bits, wraps only by explicit reload; bit_cnt 3 bits.

Decomposition:
- Shared package spi_pkg:
  - State encoding localparams (IDLE..GAP).
  - SPI_BITS=8.
  - Minimum HALF_DIV and GAP_CYC constants, shared with the receiver and checked by an elaboration assertion.
- One natural sub-module, spi_clk_div: a half-period down-counter with load and expire pulse, reused for LOW/HIGH/TRAIL/GAP timing.
- The FSM, holding register and shift register stay in spi_master_tx.

Test Plan:
- Single byte: HALF_DIV=4, send 0xA5 with last=1 → spi_ss low for exactly 68 cycles, 8 rising edges, receiver model outputs 0xA5, one byte_done pulse, spi_ss high for 8 cycles before busy=0.
- Burst: send 0x3C, 0xFF, 0x00 back-to-back, last on 0x00 → single spi_ss-low window of 3*16*4+4=196 cycles, receiver yields 0x3C, 0xFF, 0x00 in order, no STALL entered.
- Underrun: send 0x81 with last=0, wait 50 cycles, send 0x7E with last=1 → spi_clk low and spi_ss low throughout the wait, mosi stable, receiver yields 0x81 then 0x7E, one frame.
- Backpressure: hold tx_valid=1 with a changing tx_data stream of 0x01..0x04 → tx_ready deasserts while holding is full, each byte accepted exactly once, order preserved.
- Reset mid-frame: assert rstn=0 after the 3rd rising edge of 0xC3 → next cycle spi_ss=1, spi_clk=0, mosi=0, tx_ready=1. A following 0x5A frame is received correctly.
- Minimum divider: HALF_DIV=2, GAP_CYC=2, burst 0x12, 0x34 → receiver decodes both bytes, no missed edge at the byte boundary.
